// File: rtl/synth_pkg.sv
// Shared widths and DAC framing states for the synth datapath.
// Imported by voice_controller and the DAC output stage.
package synth_pkg;
   localparam int SAMPLE_W = 24;
   localparam int DAC_W    = 16;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} dac_state_e;
endpackage

// File: rtl/dac_sample_formatter.sv
// Combinational sample -> DAC word: gain shift, narrow to 16 bits, offset binary.
// DAC_SATURATE_EN selects clamping on overflow; otherwise the low 16 bits wrap.
module dac_sample_formatter
   import synth_pkg::*;
#(
   parameter int GAIN_SHIFT = 3
) (
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic [DAC_W-1:0]    o_word
);

   logic signed [SAMPLE_W-1:0] w_shifted;
   logic [DAC_W-1:0]           w_narrow;

   assign w_shifted = $signed(i_sample) >>> GAIN_SHIFT;

`ifdef DAC_SATURATE_EN
   logic w_ovf;

   // Fits in 16 signed bits only when everything above bit 14 matches the sign.
   assign w_ovf    = (w_shifted[SAMPLE_W-1:DAC_W-1] != {(SAMPLE_W-DAC_W+1){w_shifted[SAMPLE_W-1]}});
   assign w_narrow = !w_ovf               ? w_shifted[DAC_W-1:0] :
                     w_shifted[SAMPLE_W-1] ? {1'b1, {(DAC_W-1){1'b0}}} :
                                             {1'b0, {(DAC_W-1){1'b1}}};
`else
   logic w_unused;

   assign w_narrow = w_shifted[DAC_W-1:0];
   assign w_unused = ^w_shifted[SAMPLE_W-1:DAC_W];
`endif

   assign o_word = w_narrow ^ {1'b1, {(DAC_W-1){1'b0}}};

endmodule

// File: rtl/dac_output_stage.sv
// Sample-rate strobe, sample capture and MSB-first 16-bit SPI DAC shifter.
// Formatting (and the DAC_SATURATE_EN option) lives in dac_sample_formatter.
module dac_output_stage
   import synth_pkg::*;
#(
   parameter int SAMPLE_PERIOD = 1024,
   parameter int SCLK_HALF     = 4,
   parameter int GAIN_SHIFT    = 3
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic                o_sample_tick,
   output logic                o_dac_cs_n,
   output logic                o_dac_sclk,
   output logic                o_dac_mosi,
   output logic                o_busy,
   output logic                o_overrun
);

   localparam int CNT_W = $clog2(SAMPLE_PERIOD);
   localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SAMPLE_PERIOD - 2);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_HALF - 1);

   logic [CNT_W-1:0]    r_cnt;
   logic                r_tick;
   dac_state_e          r_state, w_next;
   logic [SAMPLE_W-1:0] r_sample;
   logic [DAC_W-1:0]    r_shift;
   logic [DIV_W-1:0]    r_div;
   logic [4:0]          r_rises;
   logic                r_sclk, r_cs_n, r_busy, r_ovr;
   logic [DAC_W-1:0]    w_word;
   logic                w_div_end, w_all_sent;

   dac_sample_formatter #(.GAIN_SHIFT(GAIN_SHIFT)) u_fmt (
      .i_sample (r_sample),
      .o_word   (w_word)
   );

   // Tick is registered one count early so it is high exactly while r_cnt == SAMPLE_PERIOD-1.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == CNT_PRE);
      end
   end

   assign w_div_end  = (r_div == DIV_LAST);
   assign w_all_sent = (r_rises == 5'd16);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (r_tick) w_next = LOAD;
         LOAD:    w_next = SHIFT;
         SHIFT:   if (w_div_end && r_sclk && w_all_sent) w_next = GAP;
         GAP:     if (w_div_end) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_sample <= '0;
         r_shift  <= '0;
         r_div    <= '0;
         r_rises  <= '0;
         r_sclk   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         r_busy <= (w_next != IDLE);
         r_ovr  <= r_tick && (r_state != IDLE);
         r_div  <= (r_state == IDLE || r_state == LOAD || w_div_end) ? '0 : r_div + 1'b1;
         case (r_state)
            IDLE: if (r_tick) r_sample <= i_sample;
            LOAD: begin
               r_shift <= w_word;
               r_cs_n  <= 1'b0;
               r_sclk  <= 1'b0;
               r_rises <= '0;
            end
            SHIFT: if (w_div_end) begin
               if (!r_sclk) begin
                  r_sclk  <= 1'b1;
                  r_rises <= r_rises + 1'b1;
               end else begin
                  r_sclk <= 1'b0;
                  // The falling point after the 16th rise ends the frame instead of shifting.
                  if (w_all_sent) r_cs_n  <= 1'b1;
                  else            r_shift <= {r_shift[DAC_W-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sample_tick = r_tick;
   assign o_dac_cs_n    = r_cs_n;
   assign o_dac_sclk    = r_sclk;
   assign o_dac_mosi    = r_shift[DAC_W-1];
   assign o_busy        = r_busy;
   assign o_overrun     = r_ovr;

endmodule

// File: tb/tb_dac_output_stage.sv
// Directed bench for dac_output_stage: framing, formatting, overrun and mid-frame reset.
// Expected words follow DAC_SATURATE_EN when the bundle is built with it.
module tb_dac_output_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] smp = '0;
   logic        tick, cs_n, sclk, mosi, busy, ovr;
   logic        ov_tick, ov_cs_n, ov_sclk, ov_mosi, ov_busy, ov_ovr;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int exp_tick = 1023;
   bit ov_done = 0;

`ifdef DAC_SATURATE_EN
   localparam logic [15:0] EXP_POS_OVF = 16'hFFFF;
   localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`else
   localparam logic [15:0] EXP_POS_OVF = 16'h0000;
   localparam logic [15:0] EXP_NEG_OVF = 16'hFFFF;
`endif

   always #5 clk = ~clk;

   dac_output_stage dut (
      .i_clk(clk), .i_reset(rst_n), .i_sample(smp),
      .o_sample_tick(tick), .o_dac_cs_n(cs_n), .o_dac_sclk(sclk),
      .o_dac_mosi(mosi), .o_busy(busy), .o_overrun(ovr)
   );

   dac_output_stage #(.SAMPLE_PERIOD(100), .SCLK_HALF(4)) dut_ov (
      .i_clk(clk), .i_reset(rst_n), .i_sample(smp),
      .o_sample_tick(ov_tick), .o_dac_cs_n(ov_cs_n), .o_dac_sclk(ov_sclk),
      .o_dac_mosi(ov_mosi), .o_busy(ov_busy), .o_overrun(ov_ovr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
   endtask

   // Waits for the next tick, then records one whole frame as seen on the pins.
   task automatic run_frame(input string name, input logic [23:0] s, input logic [15:0] exp_word);
      bit seen = 0;
      int idle_bad = 0;
      int t, rises = 0, cs_low = 0, n_ovr = 0, mosi_bad = 0;
      int cs_fall = -1, cs_rise = -1, first_rise = -1, busy_first = -1, busy_last = -1;
      logic [15:0] word = '0;
      logic p_sclk, p_cs, p_mosi;
      smp = s;
      for (int k = 0; k < 2100; k++) begin
         if (tick) begin
            seen = 1;
            break;
         end
         if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) idle_bad++;
         step();
      end
      chk($sformatf("%s.tick_seen", name), 32'(seen), 32'd1);
      if (!seen) return;
      chk($sformatf("%s.tick_cyc", name), cyc, exp_tick);
      chk($sformatf("%s.idle_quiet", name), idle_bad, 0);
      exp_tick += 1024;
      t = cyc;
      p_sclk = sclk; p_cs = cs_n; p_mosi = mosi;
      for (int k = 0; k < 200; k++) begin
         step();
         if (busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
         end
         if (p_cs && !cs_n) cs_fall = cyc;
         if (!p_cs && cs_n) cs_rise = cyc;
         if (!cs_n) cs_low++;
         if (!p_sclk && sclk) begin
            rises++;
            word = {word[14:0], mosi};
            if (rises == 1) first_rise = cyc;
         end
         if (mosi !== p_mosi && !(p_sclk && !sclk) && !(p_cs && !cs_n)) mosi_bad++;
         if (ovr) n_ovr++;
         p_sclk = sclk; p_cs = cs_n; p_mosi = mosi;
         if (busy_first >= 0 && !busy) break;
      end
      chk($sformatf("%s.word", name), word, exp_word);
      chk($sformatf("%s.rises", name), rises, 16);
      chk($sformatf("%s.cs_low", name), cs_low, 128);
      chk($sformatf("%s.cs_fall", name), cs_fall - t, 2);
      chk($sformatf("%s.first_rise", name), first_rise - t, 6);
      chk($sformatf("%s.cs_rise", name), cs_rise - t, 130);
      chk($sformatf("%s.busy_first", name), busy_first - t, 1);
      chk($sformatf("%s.busy_last", name), busy_last - t, 133);
      chk($sformatf("%s.mosi_stable", name), mosi_bad, 0);
      chk($sformatf("%s.no_overrun", name), n_ovr, 0);
   endtask

   // Short-period instance: ticks land mid-frame, overrun pulses, frames stay whole.
   initial begin
      int ocyc = 0, last_tick = -1000, ticks = 0, starts = 0, dones = 0, ovs = 0, bad = 0, rises = 0;
      logic p_cs = 1'b1, p_sclk = 1'b0;
      wait (rst_n === 1'b1);
      repeat (1050) begin
         @(negedge clk);
         ocyc++;
         if (ov_tick) begin
            ticks++;
            last_tick = ocyc;
         end
         if (p_cs && !ov_cs_n) begin
            starts++;
            rises = 0;
            if (ocyc - last_tick != 2) bad++;
         end
         if (!p_sclk && ov_sclk) rises++;
         if (!p_cs && ov_cs_n) begin
            dones++;
            if (rises != 16) bad++;
         end
         if (ov_ovr) begin
            ovs++;
            if (ocyc - last_tick != 1 || !ov_busy) bad++;
         end
         p_cs = ov_cs_n; p_sclk = ov_sclk;
      end
      chk("ov.ticks", ticks, 10);
      chk("ov.frames_started", starts, 5);
      chk("ov.frames_done", dones, 5);
      chk("ov.overruns", ovs, 5);
      chk("ov.frame_errors", bad, 0);
      ov_done = 1;
   end

   initial begin
      bit seen;
      int rises;
      logic p_sclk;
      repeat (3) @(negedge clk);
      chk("rst.tick", 32'(tick), 32'd0);
      chk("rst.cs_n", 32'(cs_n), 32'd1);
      chk("rst.sclk", 32'(sclk), 32'd0);
      chk("rst.mosi", 32'(mosi), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.overrun", 32'(ovr), 32'd0);
      rst_n = 1'b1;
      cyc = 0;

      run_frame("zero",    24'h000000, 16'h8000);
      run_frame("pos_max", 24'h03FFF8, 16'hFFFF);
      run_frame("neg_min", 24'hFC0000, 16'h0000);
      run_frame("pattern", 24'h00A5A8, 16'h94B5);
      run_frame("neg_pat", 24'hFF5A58, 16'h6B4B);
      run_frame("pos_ovf", 24'h040000, EXP_POS_OVF);
      run_frame("neg_ovf", 24'hFBFFF8, EXP_NEG_OVF);

      // Reset asserted right after the 7th SCLK rise of a frame.
      smp = 24'h00A5A8;
      seen = 0;
      for (int k = 0; k < 2100 && !seen; k++) begin
         step();
         if (tick) seen = 1;
      end
      chk("mid.tick_seen", 32'(seen), 32'd1);
      rises = 0;
      p_sclk = sclk;
      for (int k = 0; k < 200 && rises < 7; k++) begin
         step();
         if (!p_sclk && sclk) rises++;
         p_sclk = sclk;
      end
      chk("mid.rises_before_reset", rises, 7);
      #2 rst_n = 1'b0;
      #1;
      chk("mid.cs_n", 32'(cs_n), 32'd1);
      chk("mid.sclk", 32'(sclk), 32'd0);
      chk("mid.busy", 32'(busy), 32'd0);
      chk("mid.mosi", 32'(mosi), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
      exp_tick = 1023;
      run_frame("after_rst", 24'hFF5A58, 16'h6B4B);

      chk("ov.done", 32'(ov_done), 32'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dac_output_stage.md
# dac_output_stage

Downstream stage of `voice_controller`. It generates the audio sample-rate strobe, captures the signed 24-bit `o_mixed_sample` on each strobe, and scales it to a 16-bit word. It converts that word to offset binary and shifts it MSB-first into a 16-bit SPI DAC. It replaces the ad-hoc `mixed_sample[18:3] + 32768` expression at the top level and is the only block that drives the DAC pins.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 1024: `i_clk` cycles per audio sample; must be ≥ 33*`SCLK_HALF` + 3.
- `SCLK_HALF`, 4: `i_clk` cycles per SCLK half-period; ≥ 1.
- `GAIN_SHIFT`, 3: arithmetic right shift applied to the 24-bit sample before it is narrowed to 16 bits.

Ports:
- `i_clk`, in, 1: system clock; the only clock in the block.
- `i_reset`, in, 1: asynchronous, active-low reset.
- `i_sample`, in, 24: signed mixed sample from `voice_controller`.
- `o_sample_tick`, out, 1: one-cycle strobe at the sample rate; `voice_controller` advances its DDS/ADSR on it.
- `o_dac_cs_n`, out, 1: DAC chip select, active low.
- `o_dac_sclk`, out, 1: DAC serial clock; idles low.
- `o_dac_mosi`, out, 1: DAC serial data; stable on SCLK rising edges.
- `o_busy`, out, 1: high whenever state ≠ IDLE.
- `o_overrun`, out, 1: one-cycle pulse when a tick arrives while a frame is still in progress.

## Operation
- Tick counter counts 0..`SAMPLE_PERIOD`-1 and wraps. `o_sample_tick` is high only when the count equals `SAMPLE_PERIOD`-1.
- State machine:
  - IDLE → LOAD on a tick. `i_sample` is registered on that same edge.
  - LOAD → SHIFT. The formatted word is loaded into the 16-bit shift register, `o_dac_cs_n`=0, and `o_dac_mosi`=bit15.
  - SHIFT: SCLK toggles every `SCLK_HALF` cycles, starting low. On each falling edge the register shifts left and MOSI takes the next bit. After the 16th rising edge, the next falling point instead sets `o_dac_cs_n`=1 and moves to GAP.
  - GAP: holds CS high for `SCLK_HALF` cycles, then returns to IDLE.
- Formatting:
  - `s = i_sample >>> GAIN_SHIFT`, an arithmetic shift kept at 24 bits.
  - The result is narrowed to signed 16 bits, saturating per Configuration.
  - The DAC word is `narrowed ^ 16'h8000`, i.e. offset binary.
- Overrun: a tick in any state other than IDLE pulses `o_overrun` and drops that sample. The current frame completes untouched. The counter is never stalled.
- Asynchronous reset: every output goes immediately to its reset value and the state goes to IDLE, even mid-frame. The counter restarts at 0.
- Reset values: `o_sample_tick`=0, `o_dac_cs_n`=1, `o_dac_sclk`=0, `o_dac_mosi`=0, `o_busy`=0, `o_overrun`=0.

## Timing
- After reset release, the first tick is at cycle `SAMPLE_PERIOD`-1 (cycles counted from 0). Later ticks are exactly `SAMPLE_PERIOD` cycles apart.
- Tick at cycle T:
  - CS falls at T+2.
  - First SCLK rise at T+2+`SCLK_HALF`.
  - CS rises at T+2+32*`SCLK_HALF`.
  - `o_busy` is high from T+1 through T+1+33*`SCLK_HALF`.
- The DAC latches MOSI on SCLK rising edges. MOSI changes only on SCLK falling edges, or when CS falls.
- All outputs are registered and glitch-free. There is no combinational path from `i_sample` to any output.

## Configuration
- `DAC_SATURATE_EN` defined: values above 32767 clamp to 32767 and values below −32768 clamp to −32768.
- `DAC_SATURATE_EN` undefined: plain truncation to `s[15:0]`, which wraps on overflow. This is bit-identical to the legacy `[18:3]` slice when `GAIN_SHIFT`=3.

## Structure
- `synth_pkg` holds `SAMPLE_W`=24 and `DAC_W`=16 and the state enum (IDLE, LOAD, SHIFT, GAP). `voice_controller` imports the same package.
- One sub-module, `dac_sample_formatter`, is purely combinational. It does shift, narrowing/saturation and the offset-binary conversion, and it is the only place `DAC_SATURATE_EN` is tested.
- The top level holds the tick counter, the FSM, the SCLK divider and the shift register.

## Test plan
- Reset held, then released; defaults apply → first `o_sample_tick` at cycle 1023. Period stays 1024. All outputs at reset values beforehand.
- `i_sample`=24'sh000000 → DAC word 0x8000. `i_sample`=24'sh03FFF8 → 0xFFFF. `i_sample`=24'shFC0000 → 0x0000. Check MSB-first order, 16 SCLK rises, CS low for exactly 128 cycles.
- `i_sample`=24'sh040000 → 0xFFFF with `DAC_SATURATE_EN`, 0x0000 without. `i_sample`=24'shFBFFF8 → 0x0000 with, 0xFFFF without.
- `SAMPLE_PERIOD`=100, `SCLK_HALF`=4 → `o_overrun` pulses on each tick landing mid-frame. Frames stay intact with 16 bits each, and no frame starts without a tick.
- Reset asserted at SCLK rise 7 → CS=1 and SCLK=0 immediately. The next frame after release carries the full 16 bits.
